divider_arbiter: RTL and testbench
==================================

# divider_arbiter

Round-robin scheduler that shares one multi-cycle sequential divider core among N_REQ requesters. Each requester presents a numerator/denominator pair on a valid/ready handshake. The block grants one requester at a time, sequences the divider's valid window, and captures the quotient. It returns the quotient on a shared, tagged response channel. Divide-by-zero is handled locally without occupying the divider. The block sits between the arithmetic clients and the divider core, and is the only driver of the core's inputs.

## Interface
- DATA_WIDTH, 8, operand/quotient width; must match the divider core.
- N_REQ, 4, number of requesters, ≥2.
- TIMEOUT, 4, maximum cycles to wait for the divider's accept pulse before an error response.
- i_clk  in  1  single clock, rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_req_valid  in  N_REQ  per-requester request.
- i_req_n  in  N_REQ*DATA_WIDTH  packed numerators; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_req_d  in  N_REQ*DATA_WIDTH  packed denominators, same packing.
- o_req_ready  out  N_REQ  one-hot, one-cycle grant/accept pulse.
- o_div_n  out  DATA_WIDTH  divider numerator; stable for the whole job.
- o_div_d  out  DATA_WIDTH  divider denominator; stable for the whole job.
- o_div_valid  out  1  divider step enable.
- i_div_q  in  DATA_WIDTH  divider quotient.
- i_div_accept  in  1  divider done pulse.
- o_rsp_valid  out  1  one-cycle response pulse; no backpressure.
- o_rsp_id  out  $clog2(N_REQ)  index of the requester being answered.
- o_rsp_q  out  DATA_WIDTH  quotient.
- o_rsp_dz  out  1  divide-by-zero flag.
- o_rsp_err  out  1  divider timeout flag.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, RUN, WAIT.
- IDLE: if any i_req_valid is high, the block picks a winner round-robin. The search starts at last_grant+1 and wraps modulo N_REQ. In the same cycle it pulses o_req_ready[winner] and latches n, d and the winner's id. It updates last_grant to the winner.
  - If d==0, the block goes to no new state (stays in IDLE) and responds next cycle with q set to all ones and dz=1.
  - Otherwise it loads a step counter with DATA_WIDTH-1 and moves to RUN.
- RUN: o_div_valid=1. The counter decrements each cycle. When the counter reaches 0, the block moves to WAIT. o_div_valid is therefore high for exactly DATA_WIDTH consecutive cycles.
- WAIT: o_div_valid=0. On i_div_accept, the block registers i_div_q into o_rsp_q, pulses o_rsp_valid next cycle, and returns to IDLE. If TIMEOUT cycles pass without accept, it responds with err=1 and q=0, then returns to IDLE.
- An i_div_accept pulse outside WAIT is ignored.
- o_div_valid is never high during a cycle in which i_div_accept is high. The core clears its quotient in that cycle, so this rule prevents a lost bit.
- Requesters hold valid and operands stable until they see ready. Dropping valid before the grant is legal; such a request is simply not granted.
- The remainder is not returned; the core clears it at completion.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - last_grant is N_REQ-1, so requester 0 wins the first arbitration.
- Reset mid-job: the block returns to IDLE immediately and issues no response for the aborted job. The divider core shares i_nrst, so it aborts as well.

## Timing
- Grant cycle G: o_req_ready pulses and operands are latched at the end of G.
- Divider job:
  - RUN occupies cycles G+1 through G+DATA_WIDTH.
  - The core pulses accept at G+DATA_WIDTH+1.
  - o_rsp_valid pulses at G+DATA_WIDTH+2.
- Total latency is DATA_WIDTH+2 cycles from grant to response.
- The next grant may occur at G+DATA_WIDTH+2, the same cycle as o_rsp_valid. Its RUN window then starts at G+DATA_WIDTH+3.
- Divide-by-zero: o_rsp_valid pulses at G+1. The next grant may occur at G+1.
- o_rsp_id, o_rsp_q and o_rsp_dz/o_rsp_err hold their values until the next response. They are meaningful only while o_rsp_valid is high.

## Structure
- Package divider_arbiter_pkg contains:
  - the state enum (IDLE, RUN, WAIT);
  - an id-width function giving $clog2(N_REQ);
  - the all-ones divide-by-zero quotient constant.
- Sub-module rr_arbiter contains the combinational round-robin pick. Inputs are the request vector and last_grant. Outputs are a one-hot grant and an encoded index. It is reused by other shared arithmetic units.
- The divider core is instantiated by the parent, not inside this block.

## Test plan
All scenarios use DATA_WIDTH=8 and N_REQ=4, with the bench divider modelled as the real core.
1. Single job: requester 2 sends 100/7. Required: ready[2] pulses at G, o_div_valid is high for exactly 8 cycles, and o_rsp_valid pulses at G+10 with id=2, q=14, dz=0.
2. Contention: all four requesters are valid at once with operands 200/3, 255/255, 9/10, 64/8. Required: grants in order 0, 1, 2, 3, one response every 10 cycles, with q=66, 1, 0, 8.
3. Fairness: requesters 1 and 3 both keep valid high for 4 jobs. Required: grants alternate 1, 3, 1, 3; neither is granted twice in a row.
4. Divide-by-zero: requester 0 sends 50/0. Required: o_rsp_valid at G+1 with q=8'hFF, dz=1, and o_div_valid never asserted.
5. Timeout: the divider model withholds accept. Required: o_rsp_valid pulses TIMEOUT cycles after WAIT is entered, with err=1 and q=0. The block then returns to IDLE and serves the next request normally.
6. Reset mid-job: assert i_nrst low at G+4 of a 100/7 job. Required: all outputs read 0 during reset and no response is issued. The first request after reset from requester 0 returns the correct quotient at grant+10.

Source files
------------

// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter.
// State encoding, id width helper and the divide-by-zero quotient.
package divider_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT
  } state_t;

  localparam logic [63:0] DZ_Q_ALL = '1;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over a request vector.
// Search starts one past i_last and wraps around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_best;
  int w_dist;

  // Distance from the slot after i_last; the smallest one wins.
  always_comb begin
    w_best = N;
    w_dist = 0;
    o_idx  = '0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - int'(i_last) - 1) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IW'(i);
      end
    end
  end

  always_comb begin
    o_any = |i_req;
    o_gnt = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = o_any && (o_idx == IW'(i));
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one sequential divider core.
// Sequences the core's valid window and returns tagged quotients.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_n,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_d,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]       o_div_n,
  output logic [DATA_WIDTH-1:0]       o_div_d,
  output logic                        o_div_valid,
  input  logic [DATA_WIDTH-1:0]       i_div_q,
  input  logic                        i_div_accept,
  output logic                        o_rsp_valid,
  output logic [id_w(N_REQ)-1:0]      o_rsp_id,
  output logic [DATA_WIDTH-1:0]       o_rsp_q,
  output logic                        o_rsp_dz,
  output logic                        o_rsp_err,
  output logic                        o_busy
);

  localparam int IW   = id_w(N_REQ);
  localparam int CMAX = (DATA_WIDTH > TIMEOUT) ? DATA_WIDTH : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [DATA_WIDTH-1:0] DZ_Q = DZ_Q_ALL[DATA_WIDTH-1:0];

  state_t                r_state, w_nstate;
  logic [IW-1:0]         r_last, w_last;
  logic [IW-1:0]         r_id, w_id;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_n, w_n;
  logic [DATA_WIDTH-1:0] r_d, w_d;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [IW-1:0]         r_rsp_id, w_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_q, w_rsp_q;
  logic                  r_rsp_dz, w_rsp_dz;
  logic                  r_rsp_err, w_rsp_err;

  logic [N_REQ-1:0]      w_gnt;
  logic [N_REQ-1:0]      w_ready;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_sel_n;
  logic [DATA_WIDTH-1:0] w_sel_d;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .i_req  (i_req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_sel_n = '0;
    w_sel_d = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_n = i_req_n[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_d = i_req_d[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_nstate    = r_state;
    w_last      = r_last;
    w_id        = r_id;
    w_cnt       = r_cnt;
    w_n         = r_n;
    w_d         = r_d;
    w_ready     = '0;
    w_rsp_valid = 1'b0;
    w_rsp_id    = r_rsp_id;
    w_rsp_q     = r_rsp_q;
    w_rsp_dz    = r_rsp_dz;
    w_rsp_err   = r_rsp_err;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ready = w_gnt;
          w_last  = w_idx;
          w_id    = w_idx;
          w_n     = w_sel_n;
          w_d     = w_sel_d;
          // Zero divisor is answered locally; the core never sees it.
          if (w_sel_d == '0) begin
            w_rsp_valid = 1'b1;
            w_rsp_id    = w_idx;
            w_rsp_q     = DZ_Q;
            w_rsp_dz    = 1'b1;
            w_rsp_err   = 1'b0;
          end else begin
            w_cnt    = CW'(DATA_WIDTH - 1);
            w_nstate = RUN;
          end
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_nstate = WAIT;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      WAIT: begin
        if (i_div_accept) begin
          w_rsp_valid = 1'b1;
          w_rsp_id    = r_id;
          w_rsp_q     = i_div_q;
          w_rsp_dz    = 1'b0;
          w_rsp_err   = 1'b0;
          w_nstate    = IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_rsp_valid = 1'b1;
          w_rsp_id    = r_id;
          w_rsp_q     = '0;
          w_rsp_dz    = 1'b0;
          w_rsp_err   = 1'b1;
          w_nstate    = IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= IDLE;
      r_last      <= IW'(N_REQ - 1);
      r_id        <= '0;
      r_cnt       <= '0;
      r_n         <= '0;
      r_d         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
      r_rsp_dz    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_last      <= w_last;
      r_id        <= w_id;
      r_cnt       <= w_cnt;
      r_n         <= w_n;
      r_d         <= w_d;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_id    <= w_rsp_id;
      r_rsp_q     <= w_rsp_q;
      r_rsp_dz    <= w_rsp_dz;
      r_rsp_err   <= w_rsp_err;
    end
  end

  // Grant pulse is combinational; hold it low while reset is applied.
  assign o_req_ready = w_ready & {N_REQ{i_nrst}};
  assign o_div_n     = r_n;
  assign o_div_d     = r_d;
  assign o_div_valid = (r_state == RUN);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_q     = r_rsp_q;
  assign o_rsp_dz    = r_rsp_dz;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level model.
module tb_divider_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 4;

  typedef struct {
    int cyc;
    int id;
    int q;
    int dz;
    int err;
  } rsp_t;

  logic          clk;
  logic          nrst;
  logic [NR-1:0] req_v;
  logic [NR*DW-1:0] req_n;
  logic [NR*DW-1:0] req_d;
  logic [NR-1:0] ready;
  logic [DW-1:0] div_n;
  logic [DW-1:0] div_d;
  logic          div_v;
  logic [DW-1:0] div_q;
  logic          div_acc;
  logic          rsp_v;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_q;
  logic          rsp_dz;
  logic          rsp_err;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int free_at = 0;
  int last_m = NR - 1;
  int last_g = 0;
  int run_lo = 1;
  int run_hi = 0;
  int job_n = 0;
  int job_d = 0;
  int g_w = -1;
  int dv_seen = 0;
  int reload [NR];
  bit withhold = 0;
  rsp_t exp_q[$];
  int grants[$];
  int dcnt = 0;

  divider_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (NR),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_req_valid  (req_v),
    .i_req_n      (req_n),
    .i_req_d      (req_d),
    .o_req_ready  (ready),
    .o_div_n      (div_n),
    .o_div_d      (div_d),
    .o_div_valid  (div_v),
    .i_div_q      (div_q),
    .i_div_accept (div_acc),
    .o_rsp_valid  (rsp_v),
    .o_rsp_id     (rsp_id),
    .o_rsp_q      (rsp_q),
    .o_rsp_dz     (rsp_dz),
    .o_rsp_err    (rsp_err),
    .o_busy       (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Divider core model: after a full window of DW steps, accept next cycle.
  always @(negedge clk) begin
    if (!nrst) begin
      dcnt = 0;
      div_acc = 0;
    end else begin
      div_acc = 0;
      if (div_v) begin
        dcnt++;
      end else if (dcnt == DW) begin
        dcnt = 0;
        if (!withhold) begin
          div_acc = 1;
          div_q = DW'(int'(div_n) / int'(div_d));
        end
      end else begin
        dcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    int k;
    for (int i = 1; i <= NR; i++) begin
      k = (last + i) % NR;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic cycle();
    int w;
    int n;
    int d;
    rsp_t r;
    @(negedge clk);
    g_w = -1;
    if (!nrst) begin
      chk("rst_ready", 32'(ready), 0);
      chk("rst_div_valid", 32'(div_v), 0);
      chk("rst_div_n", 32'(div_n), 0);
      chk("rst_div_d", 32'(div_d), 0);
      chk("rst_rsp_valid", 32'(rsp_v), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_q", 32'(rsp_q), 0);
      chk("rst_rsp_flags", {30'd0, rsp_dz, rsp_err}, 0);
      chk("rst_busy", 32'(busy), 0);
    end else begin
      chk("busy", 32'(busy), 32'(cyc < free_at));
      chk("div_valid", 32'(div_v), 32'(cyc >= run_lo && cyc <= run_hi));
      if (div_v) dv_seen++;
      if (cyc >= run_lo && cyc <= run_hi) begin
        chk("div_n", 32'(div_n), 32'(job_n));
        chk("div_d", 32'(div_d), 32'(job_d));
      end
      w = -1;
      if (cyc >= free_at && req_v != 0) begin
        w = rr_pick(req_v, last_m);
        last_m = w;
        last_g = cyc;
        grants.push_back(w);
        n = int'(req_n[w*DW +: DW]);
        d = int'(req_d[w*DW +: DW]);
        if (d == 0) begin
          r = '{cyc + 1, w, 255, 1, 0};
          free_at = cyc + 1;
        end else begin
          job_n = n;
          job_d = d;
          run_lo = cyc + 1;
          run_hi = cyc + DW;
          if (withhold) begin
            r = '{cyc + DW + 1 + TO, w, 0, 0, 1};
          end else begin
            r = '{cyc + DW + 2, w, n / d, 0, 0};
          end
          free_at = r.cyc;
        end
        exp_q.push_back(r);
      end
      chk("req_ready", 32'(ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        r = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_v), 1);
        chk("rsp_id", 32'(rsp_id), 32'(r.id));
        chk("rsp_q", 32'(rsp_q), 32'(r.q));
        chk("rsp_dz", 32'(rsp_dz), 32'(r.dz));
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
      end else begin
        chk("rsp_idle", 32'(rsp_v), 0);
      end
      g_w = w;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g_w >= 0) begin
      if (reload[g_w] > 0) begin
        reload[g_w]--;
        req_n[g_w*DW +: DW] = DW'($urandom_range(255));
        req_d[g_w*DW +: DW] = DW'($urandom_range(255, 1));
      end else begin
        req_v[g_w] = 0;
      end
    end
  endtask

  task automatic put(input int k, input int n, input int d);
    req_v[k] = 1;
    req_n[k*DW +: DW] = DW'(n);
    req_d[k*DW +: DW] = DW'(d);
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while ((exp_q.size() > 0 || req_v != 0 || cyc < free_at) && i < 300) begin
      cycle();
      i++;
    end
    chk(tag, 32'(i < 300), 1);
  endtask

  initial begin
    nrst = 0;
    req_v = '0;
    req_n = '0;
    req_d = '0;
    div_q = '0;
    for (int k = 0; k < NR; k++) reload[k] = 0;
    #2;
    cycle();
    cycle();
    nrst = 1;
    cycle();

    // Contention right after reset: requester 0 first.
    grants.delete();
    put(0, 200, 3);
    put(1, 255, 255);
    put(2, 9, 10);
    put(3, 64, 8);
    drain("s2_drain");
    chk("s2_ngrant", 32'(grants.size()), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("s2_order", 32'(grants[i]), 32'(i));

    // Fairness: 1 and 3 keep valid high for two jobs each.
    grants.delete();
    reload[1] = 1;
    reload[3] = 1;
    put(1, 77, 7);
    put(3, 99, 4);
    drain("s3_drain");
    chk("s3_ngrant", 32'(grants.size()), 4);
    if (grants.size() == 4) begin
      chk("s3_g0", 32'(grants[0]), 1);
      chk("s3_g1", 32'(grants[1]), 3);
      chk("s3_g2", 32'(grants[2]), 1);
      chk("s3_g3", 32'(grants[3]), 3);
    end

    // Single job from requester 2.
    dv_seen = 0;
    put(2, 100, 7);
    drain("s1_drain");
    chk("s1_dv_cycles", 32'(dv_seen), 8);

    // Divide by zero.
    dv_seen = 0;
    put(0, 50, 0);
    drain("s4_drain");
    chk("s4_no_dv", 32'(dv_seen), 0);

    // Timeout, then a normal job.
    withhold = 1;
    put(1, 77, 5);
    drain("s5_drain");
    withhold = 0;
    put(2, 90, 9);
    drain("s5b_drain");

    // Reset in the middle of a job.
    grants.delete();
    put(2, 100, 7);
    for (int i = 0; i < 20 && grants.size() == 0; i++) cycle();
    chk("s6_granted", 32'(grants.size()), 1);
    while (cyc < last_g + 4) cycle();
    nrst = 0;
    req_v = '0;
    cycle();
    cycle();
    exp_q.delete();
    free_at = cyc;
    last_m = NR - 1;
    run_lo = 1;
    run_hi = 0;
    nrst = 1;
    for (int i = 0; i < 4; i++) cycle();
    grants.delete();
    put(0, 100, 7);
    drain("s6_drain");
    chk("s6_first", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF, 0);

    // Random traffic, with occasional zero divisors and withdrawals.
    for (int c = 0; c < 400; c++) begin
      cycle();
      for (int k = 0; k < NR; k++) begin
        if (!req_v[k] && $urandom_range(3) == 0) begin
          put(k, int'($urandom_range(255)),
              ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255, 1)));
        end else if (req_v[k] && $urandom_range(31) == 0) begin
          req_v[k] = 0;
        end
      end
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
